// File: rtl/riscv_fetch_buffer_if.sv
// riscv_fetch_buffer_if: fetch/decode/imem signals of the fetch buffer.
// master is the buffer's view; slave is the surrounding pipeline and memory.
interface riscv_fetch_buffer_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] i_PCF;
    logic [XLEN-1:0] i_PCPlus4F;
    logic            i_stallD;
    logic            i_flushD;
    logic            o_stallF;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ready;
    logic            i_imem_rvalid;
    logic [31:0]     i_imem_rdata;
    logic [31:0]     o_instrD;
    logic [XLEN-1:0] o_PCD;
    logic [XLEN-1:0] o_PCPlus4D;
    logic            o_validD;
    logic            o_err;

    modport master (
        input  i_PCF, i_PCPlus4F, i_stallD, i_flushD, i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output o_stallF, o_imem_req, o_imem_addr, o_instrD, o_PCD, o_PCPlus4D, o_validD, o_err
    );
    modport slave (
        output i_PCF, i_PCPlus4F, i_stallD, i_flushD, i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  o_stallF, o_imem_req, o_imem_addr, o_instrD, o_PCD, o_PCPlus4D, o_validD, o_err
    );
endinterface

// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer: tagged in-order imem request queue feeding the IF/ID register.
// An arriving response for the head entry bypasses straight into IF/ID.
module riscv_fetch_buffer #(
    parameter int          XLEN  = 32,
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input logic                 i_clk,
    input logic                 i_rst,
    riscv_fetch_buffer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc4_q [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q, ep_q;
    logic [AW-1:0]   alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [AW:0]     count_q, count_d, out_q, out_d;
    logic            epoch_q, epoch_d, err_q, err_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
    logic            id_valid_q, id_valid_d;
    logic            accept, resp, head_rdy, stale, live, pop;
    logic [31:0]     head_ins;

    always_comb begin
        bus.o_imem_req  = !i_rst && !bus.i_flushD && (count_q < FULL);
        bus.o_imem_addr = bus.i_PCF;
        accept          = bus.o_imem_req && bus.i_imem_ready;
        bus.o_stallF    = !bus.i_flushD && !accept;
        resp            = bus.i_imem_rvalid && (out_q != '0);
        head_rdy        = (count_q != '0) && (filled_q[head_q] || (resp && fill_q == head_q));
        head_ins        = filled_q[head_q] ? instr_q[head_q] : bus.i_imem_rdata;
        stale           = head_rdy && (ep_q[head_q] != epoch_q);
        live            = head_rdy && !stale;
        // wrong-path heads drain regardless of decode stall
        pop             = stale || (live && !bus.i_stallD && !bus.i_flushD);
        alloc_d         = alloc_q + AW'(accept);
        fill_d          = fill_q + AW'(resp);
        head_d          = head_q + AW'(pop);
        count_d         = count_q + (AW+1)'(accept) - (AW+1)'(pop);
        out_d           = out_q + (AW+1)'(accept) - (AW+1)'(resp);
        epoch_d         = epoch_q ^ bus.i_flushD;
        err_d           = err_q || (bus.i_imem_rvalid && out_q == '0);
        id_pc_d         = (live && !bus.i_stallD && !bus.i_flushD) ? pc_q[head_q] : id_pc_q;
        id_pc4_d        = (live && !bus.i_stallD && !bus.i_flushD) ? pc4_q[head_q] : id_pc4_q;
        id_valid_d      = bus.i_flushD ? 1'b0 : bus.i_stallD ? id_valid_q : live;
        id_instr_d      = bus.i_flushD ? NOP : bus.i_stallD ? id_instr_q : live ? head_ins : NOP;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            out_q      <= '0;
            epoch_q    <= 1'b0;
            err_q      <= 1'b0;
            filled_q   <= '0;
            id_instr_q <= NOP;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            count_q    <= count_d;
            out_q      <= out_d;
            epoch_q    <= epoch_d;
            err_q      <= err_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            if (accept) begin
                pc_q[alloc_q]     <= bus.i_PCF;
                pc4_q[alloc_q]    <= bus.i_PCPlus4F;
                ep_q[alloc_q]     <= epoch_q;
                filled_q[alloc_q] <= 1'b0;
            end
            if (resp) begin
                instr_q[fill_q]  <= bus.i_imem_rdata;
                filled_q[fill_q] <= 1'b1;
            end
        end
    end

    assign bus.o_instrD   = id_instr_q;
    assign bus.o_PCD      = id_pc_q;
    assign bus.o_PCPlus4D = id_pc4_q;
    assign bus.o_validD   = id_valid_q;
    assign bus.o_err      = err_q;
endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// tb_riscv_fetch_buffer: directed scenarios for the fetch buffer; memory responses
// are driven by hand, and the instruction word for PC a is always 0xA0000000 | a.
module tb_riscv_fetch_buffer;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    riscv_fetch_buffer_if #(.XLEN(32)) bif ();
    riscv_fetch_buffer #(.XLEN(32), .DEPTH(2)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bif));

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pcf, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input logic st, input logic fl);
        bif.i_PCF         = pcf;
        bif.i_PCPlus4F    = pcf + 32'd4;
        bif.i_imem_ready  = rdy;
        bif.i_imem_rvalid = rv;
        bif.i_imem_rdata  = ins(rpc);
        bif.i_stallD      = st;
        bif.i_flushD      = fl;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(0, 1, 0, 0, 0, 0);
        tick();
        tick();
        checks++; if (bif.o_validD !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bif.o_validD); end
        checks++; if (bif.o_instrD !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp 00000013", bif.o_instrD); end
        checks++; if (bif.o_PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd got %h exp 0", bif.o_PCD); end
        checks++; if (bif.o_PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4d got %h exp 0", bif.o_PCPlus4D); end
        checks++; if (bif.o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bif.o_err); end
        checks++; if (bif.o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bif.o_imem_req); end
        i_rst = 1'b0;
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] pc;
            pc = 32'(i) * 4;
            drive(pc, i < 4, i > 0, pc - 32'd4, 0, 0);
            checks++; if (bif.o_stallF !== (i == 4)) begin errors++; $display("FAIL stream_stallF[%0d] got %b exp %b", i, bif.o_stallF, i == 4); end
            if (i < 4) begin
                checks++; if (bif.o_imem_addr !== pc) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, bif.o_imem_addr, pc); end
            end
            tick();
            checks++; if (bif.o_validD !== (i > 0)) begin errors++; $display("FAIL stream_valid[%0d] got %b exp %b", i, bif.o_validD, i > 0); end
            if (i > 0) begin
                checks++; if (bif.o_PCD !== pc - 32'd4) begin errors++; $display("FAIL stream_pcd[%0d] got %h exp %h", i, bif.o_PCD, pc - 32'd4); end
                checks++; if (bif.o_PCPlus4D !== pc) begin errors++; $display("FAIL stream_pc4d[%0d] got %h exp %h", i, bif.o_PCPlus4D, pc); end
                checks++; if (bif.o_instrD !== ins(pc - 32'd4)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, bif.o_instrD, ins(pc - 32'd4)); end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            drive(32'h10, 0, 0, 0, 0, 0);
            checks++; if (bif.o_stallF !== 1'b1) begin errors++; $display("FAIL bp_stallF[%0d] got %b exp 1", i, bif.o_stallF); end
            checks++; if (bif.o_imem_req !== 1'b1) begin errors++; $display("FAIL bp_req[%0d] got %b exp 1", i, bif.o_imem_req); end
            checks++; if (bif.o_imem_addr !== 32'h10) begin errors++; $display("FAIL bp_addr[%0d] got %h exp 10", i, bif.o_imem_addr); end
            tick();
        end
        checks++; if (bif.o_validD !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b exp 0", bif.o_validD); end
        drive(32'h10, 1, 0, 0, 0, 0);
        checks++; if (bif.o_stallF !== 1'b0) begin errors++; $display("FAIL bp_release_stallF got %b exp 0", bif.o_stallF); end
        tick();
        drive(32'h14, 0, 1, 32'h10, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h10) begin errors++; $display("FAIL bp_issue got valid %b pc %h exp 1 10", bif.o_validD, bif.o_PCD); end
        drive(32'h14, 0, 0, 0, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b0) begin errors++; $display("FAIL bp_single got valid %b exp 0", bif.o_validD); end
    endtask

    task automatic test_decode_stall();
        drive(32'h40, 1, 0, 0, 1, 0);
        tick();
        drive(32'h44, 1, 1, 32'h40, 1, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b0) begin errors++; $display("FAIL stall_hold got valid %b exp 0", bif.o_validD); end
        for (int i = 0; i < 2; i++) begin
            drive(32'h48, 1, i == 0, 32'h44, 1, 0);
            checks++; if (bif.o_imem_req !== 1'b0 || bif.o_stallF !== 1'b1) begin errors++; $display("FAIL stall_full[%0d] got req %b stallF %b exp 0 1", i, bif.o_imem_req, bif.o_stallF); end
            tick();
        end
        drive(32'h48, 1, 0, 0, 0, 0);
        checks++; if (bif.o_stallF !== 1'b1) begin errors++; $display("FAIL stall_nocredit got %b exp 1", bif.o_stallF); end
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h40 || bif.o_instrD !== ins(32'h40)) begin errors++; $display("FAIL stall_first got %b %h %h exp 1 40 %h", bif.o_validD, bif.o_PCD, bif.o_instrD, ins(32'h40)); end
        drive(32'h48, 1, 0, 0, 0, 0);
        checks++; if (bif.o_stallF !== 1'b0) begin errors++; $display("FAIL stall_credit got %b exp 0", bif.o_stallF); end
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h44 || bif.o_instrD !== ins(32'h44)) begin errors++; $display("FAIL stall_second got %b %h %h exp 1 44 %h", bif.o_validD, bif.o_PCD, bif.o_instrD, ins(32'h44)); end
        drive(32'h4c, 0, 1, 32'h48, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h48) begin errors++; $display("FAIL stall_third got %b %h exp 1 48", bif.o_validD, bif.o_PCD); end
        drive(32'h4c, 0, 0, 0, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b0) begin errors++; $display("FAIL stall_nodup got %b exp 0", bif.o_validD); end
    endtask

    task automatic test_flush();
        drive(32'h20, 1, 0, 0, 0, 0);
        tick();
        drive(32'h24, 1, 0, 0, 0, 0);
        tick();
        drive(32'h28, 1, 0, 0, 0, 1);
        checks++; if (bif.o_imem_req !== 1'b0 || bif.o_stallF !== 1'b0) begin errors++; $display("FAIL flush_req got req %b stallF %b exp 0 0", bif.o_imem_req, bif.o_stallF); end
        tick();
        checks++; if (bif.o_validD !== 1'b0 || bif.o_instrD !== 32'h13) begin errors++; $display("FAIL flush_slot got %b %h exp 0 00000013", bif.o_validD, bif.o_instrD); end
        drive(32'h100, 1, 1, 32'h20, 0, 0);
        checks++; if (bif.o_stallF !== 1'b1) begin errors++; $display("FAIL flush_full got %b exp 1", bif.o_stallF); end
        tick();
        checks++; if (bif.o_validD !== 1'b0) begin errors++; $display("FAIL flush_drop20 got %b exp 0", bif.o_validD); end
        drive(32'h100, 1, 1, 32'h24, 0, 0);
        checks++; if (bif.o_stallF !== 1'b0) begin errors++; $display("FAIL flush_redirect_accept got %b exp 0", bif.o_stallF); end
        tick();
        checks++; if (bif.o_validD !== 1'b0) begin errors++; $display("FAIL flush_drop24 got %b exp 0", bif.o_validD); end
        drive(32'h104, 0, 1, 32'h100, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h100 || bif.o_instrD !== ins(32'h100)) begin errors++; $display("FAIL flush_target got %b %h %h exp 1 100 %h", bif.o_validD, bif.o_PCD, bif.o_instrD, ins(32'h100)); end
        drive(32'h104, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_flush_stall();
        drive(32'h200, 1, 0, 0, 0, 0);
        tick();
        drive(32'h204, 0, 1, 32'h200, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h200) begin errors++; $display("FAIL fs_setup got %b %h exp 1 200", bif.o_validD, bif.o_PCD); end
        drive(32'h204, 0, 0, 0, 1, 1);
        tick();
        checks++; if (bif.o_validD !== 1'b0 || bif.o_instrD !== 32'h13) begin errors++; $display("FAIL fs_kill got %b %h exp 0 00000013", bif.o_validD, bif.o_instrD); end
        drive(32'h204, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_spurious_reset();
        drive(32'h300, 0, 1, 32'h999, 0, 0);
        tick();
        checks++; if (bif.o_err !== 1'b1 || bif.o_validD !== 1'b0) begin errors++; $display("FAIL spur_err got err %b valid %b exp 1 0", bif.o_err, bif.o_validD); end
        drive(32'h300, 1, 0, 0, 0, 0);
        checks++; if (bif.o_imem_req !== 1'b1) begin errors++; $display("FAIL spur_req got %b exp 1", bif.o_imem_req); end
        tick();
        drive(32'h304, 0, 1, 32'h300, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h300 || bif.o_err !== 1'b1) begin errors++; $display("FAIL spur_after got %b %h err %b exp 1 300 1", bif.o_validD, bif.o_PCD, bif.o_err); end
        drive(32'h304, 1, 0, 0, 0, 0);
        tick();
        i_rst = 1'b1;
        drive(32'h308, 1, 0, 0, 0, 0);
        checks++; if (bif.o_imem_req !== 1'b0) begin errors++; $display("FAIL mrst_req got %b exp 0", bif.o_imem_req); end
        tick();
        checks++; if (bif.o_validD !== 1'b0 || bif.o_instrD !== 32'h13 || bif.o_PCD !== 32'h0 || bif.o_PCPlus4D !== 32'h0 || bif.o_err !== 1'b0) begin errors++; $display("FAIL mrst_out got %b %h %h %h %b exp 0 00000013 0 0 0", bif.o_validD, bif.o_instrD, bif.o_PCD, bif.o_PCPlus4D, bif.o_err); end
        i_rst = 1'b0;
        drive(32'h400, 1, 0, 0, 0, 0);
        tick();
        drive(32'h404, 0, 1, 32'h400, 0, 0);
        tick();
        checks++; if (bif.o_validD !== 1'b1 || bif.o_PCD !== 32'h400) begin errors++; $display("FAIL mrst_empty got %b %h exp 1 400", bif.o_validD, bif.o_PCD); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_decode_stall();
        test_flush();
        test_flush_stall();
        test_spurious_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
